mc_ctrl: RTL and testbench

// - Multi-cycle MIPS control FSM. Sequences the shared ALU, register file, IR/MDR and unified memory

---
 rtl/mc_ctrl_pkg.sv | 89 ++++++++
 rtl/mc_ctrl_if.sv | 13 +
 rtl/mc_ctrl_alu_dec.sv | 52 +++++
 rtl/mc_ctrl.sv | 135 +++++++++++++
 tb/tb_mc_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, funct codes,
// ALU operation codes, FSM states and the bundled control-output word.
package mc_ctrl_pkg;

  localparam int OP_W    = 6;
  localparam int ALUOP_W = 5;

  typedef logic [OP_W-1:0]    op_t;
  typedef logic [ALUOP_W-1:0] aluop_t;

  localparam aluop_t ALU_NOP  = 5'd0;
  localparam aluop_t ALU_ADD  = 5'd1;
  localparam aluop_t ALU_ADDU = 5'd2;
  localparam aluop_t ALU_SUB  = 5'd3;
  localparam aluop_t ALU_SUBU = 5'd4;
  localparam aluop_t ALU_AND  = 5'd5;
  localparam aluop_t ALU_OR   = 5'd6;
  localparam aluop_t ALU_NOR  = 5'd7;
  localparam aluop_t ALU_XOR  = 5'd8;
  localparam aluop_t ALU_SLT  = 5'd9;
  localparam aluop_t ALU_SLTU = 5'd10;
  localparam aluop_t ALU_SLL  = 5'd11;
  localparam aluop_t ALU_SRL  = 5'd12;
  localparam aluop_t ALU_SRA  = 5'd13;
  localparam aluop_t ALU_SLLV = 5'd14;
  localparam aluop_t ALU_SRLV = 5'd15;
  localparam aluop_t ALU_SRAV = 5'd16;

  localparam op_t OP_RTYPE = 6'h00;
  localparam op_t OP_J     = 6'h02;
  localparam op_t OP_JAL   = 6'h03;
  localparam op_t OP_BEQ   = 6'h04;
  localparam op_t OP_BNE   = 6'h05;
  localparam op_t OP_ADDI  = 6'h08;
  localparam op_t OP_ADDIU = 6'h09;
  localparam op_t OP_SLTI  = 6'h0A;
  localparam op_t OP_ANDI  = 6'h0C;
  localparam op_t OP_ORI   = 6'h0D;
  localparam op_t OP_XORI  = 6'h0E;
  localparam op_t OP_LW    = 6'h23;
  localparam op_t OP_SW    = 6'h2B;

  localparam op_t F_SLL  = 6'h00;
  localparam op_t F_SRL  = 6'h02;
  localparam op_t F_SRA  = 6'h03;
  localparam op_t F_SLLV = 6'h04;
  localparam op_t F_SRLV = 6'h06;
  localparam op_t F_SRAV = 6'h07;
  localparam op_t F_ADD  = 6'h20;
  localparam op_t F_ADDU = 6'h21;
  localparam op_t F_SUB  = 6'h22;
  localparam op_t F_SUBU = 6'h23;
  localparam op_t F_AND  = 6'h24;
  localparam op_t F_OR   = 6'h25;
  localparam op_t F_XOR  = 6'h26;
  localparam op_t F_NOR  = 6'h27;
  localparam op_t F_SLT  = 6'h2A;
  localparam op_t F_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    S_IF, S_ID, S_EXR, S_EXI, S_WB, S_MA, S_MR, S_WM, S_MW, S_BR, S_JMP
  } state_t;

  typedef enum logic [1:0] {PC_ALU = 2'd0, PC_ALUOUT = 2'd1, PC_JUMP = 2'd2} pc_src_e;
  typedef enum logic [1:0] {RD_RT = 2'd0, RD_RD = 2'd1, RD_R31 = 2'd2} reg_dst_e;
  typedef enum logic [1:0] {WD_ALUOUT = 2'd0, WD_MDR = 2'd1, WD_PC = 2'd2} wd_sel_e;
  typedef enum logic [1:0] {SRCA_PC = 2'd0, SRCA_REG = 2'd1, SRCA_SHAMT = 2'd2} srca_e;
  typedef enum logic [1:0] {
    SRCB_REG = 2'd0, SRCB_FOUR = 2'd1, SRCB_IMM = 2'd2, SRCB_IMM_SH = 2'd3
  } srcb_e;

  typedef struct packed {
    logic     pc_write;
    pc_src_e  pc_src;
    logic     iord;
    logic     mem_read;
    logic     mem_write;
    logic     ir_write;
    logic     reg_write;
    reg_dst_e reg_dst;
    wd_sel_e  wd_sel;
    srca_e    alu_srca;
    srcb_e    alu_srcb;
    logic     ext_op;
    aluop_t   alu_op;
    logic     illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and status in, control word out.
interface mc_ctrl_if;
  import mc_ctrl_pkg::*;

  op_t   op;
  op_t   funct;
  logic  zero;
  logic  mem_rdy;
  ctrl_t ctl;

  modport master (input op, funct, zero, mem_rdy, output ctl);
  modport slave  (output op, funct, zero, mem_rdy, input ctl);
endinterface

// File: rtl/mc_ctrl_alu_dec.sv
// ALU decode for R-type funct and I-type ALU opcodes; shared by EXR and EXI.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  op_t    op,
  input  op_t    funct,
  output aluop_t alu_op,
  output logic   shamt_sel,
  output logic   zext,
  output logic   valid
);

  // NOTE: every output gets a default before the case so no path leaves a latch.
  always_comb begin
    alu_op    = ALU_NOP;
    shamt_sel = 1'b0;
    zext      = 1'b0;
    valid     = 1'b1;
    if (op == OP_RTYPE) begin
      case (funct)
        F_ADD:  alu_op = ALU_ADD;
        F_ADDU: alu_op = ALU_ADDU;
        F_SUB:  alu_op = ALU_SUB;
        F_SUBU: alu_op = ALU_SUBU;
        F_AND:  alu_op = ALU_AND;
        F_OR:   alu_op = ALU_OR;
        F_NOR:  alu_op = ALU_NOR;
        F_XOR:  alu_op = ALU_XOR;
        F_SLT:  alu_op = ALU_SLT;
        F_SLTU: alu_op = ALU_SLTU;
        F_SLLV: alu_op = ALU_SLLV;
        F_SRLV: alu_op = ALU_SRLV;
        F_SRAV: alu_op = ALU_SRAV;
        F_SLL:  begin alu_op = ALU_SLL; shamt_sel = 1'b1; end
        F_SRL:  begin alu_op = ALU_SRL; shamt_sel = 1'b1; end
        F_SRA:  begin alu_op = ALU_SRA; shamt_sel = 1'b1; end
        default: valid = 1'b0;
      endcase
    end else begin
      case (op)
        OP_ADDI:  alu_op = ALU_ADD;
        OP_ADDIU: alu_op = ALU_ADDU;
        OP_SLTI:  alu_op = ALU_SLT;
        OP_ANDI:  begin alu_op = ALU_AND; zext = 1'b1; end
        OP_ORI:   begin alu_op = ALU_OR;  zext = 1'b1; end
        OP_XORI:  begin alu_op = ALU_XOR; zext = 1'b1; end
        default:  valid = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch, decode, execute, memory and
// write-back for one instruction at a time over a shared ALU and memory port.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  mc_ctrl_if.master  bus
);

  state_t state, state_nxt;
  logic   from_r;
  ctrl_t  c;
  aluop_t dec_alu_op;
  logic   dec_shamt, dec_zext, dec_valid;

  mc_alu_dec u_dec (
    .op        (bus.op),
    .funct     (bus.funct),
    .alu_op    (dec_alu_op),
    .shamt_sel (dec_shamt),
    .zext      (dec_zext),
    .valid     (dec_valid)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IF;
      from_r <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_EXR)      from_r <= 1'b1;
      else if (state == S_EXI) from_r <= 1'b0;
    end
  end

  always_comb begin
    c         = '0;
    c.alu_op  = ALU_NOP;
    state_nxt = state;
    unique case (state)
      S_IF: begin
        c.mem_read = 1'b1;
        c.alu_srcb = SRCB_FOUR;
        c.alu_op   = ALU_ADDU;
        if (bus.mem_rdy) begin
          c.ir_write = 1'b1;
          c.pc_write = 1'b1;
          state_nxt  = S_ID;
        end
      end
      S_ID: begin
        c.alu_srcb = SRCB_IMM_SH;
        c.ext_op   = 1'b1;
        c.alu_op   = ALU_ADDU;
        if (dec_valid)                             state_nxt = (bus.op == OP_RTYPE) ? S_EXR : S_EXI;
        else if (bus.op == OP_LW || bus.op == OP_SW)  state_nxt = S_MA;
        else if (bus.op == OP_BEQ || bus.op == OP_BNE) state_nxt = S_BR;
        else if (bus.op == OP_J || bus.op == OP_JAL)  state_nxt = S_JMP;
        else begin
          c.illegal = 1'b1;
          state_nxt = S_IF;
        end
      end
      S_EXR: begin
        c.alu_srca = dec_shamt ? SRCA_SHAMT : SRCA_REG;
        c.alu_srcb = SRCB_REG;
        c.alu_op   = dec_alu_op;
        state_nxt  = S_WB;
      end
      S_EXI: begin
        c.alu_srca = SRCA_REG;
        c.alu_srcb = SRCB_IMM;
        c.ext_op   = ~dec_zext;
        c.alu_op   = dec_alu_op;
        state_nxt  = S_WB;
      end
      S_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = from_r ? RD_RD : RD_RT;
        state_nxt   = S_IF;
      end
      S_MA: begin
        c.alu_srca = SRCA_REG;
        c.alu_srcb = SRCB_IMM;
        c.ext_op   = 1'b1;
        c.alu_op   = ALU_ADD;
        state_nxt  = (bus.op == OP_LW) ? S_MR : S_MW;
      end
      S_MR: begin
        c.iord     = 1'b1;
        c.mem_read = 1'b1;
        if (bus.mem_rdy) state_nxt = S_WM;
      end
      S_WM: begin
        c.reg_write = 1'b1;
        c.wd_sel    = WD_MDR;
        state_nxt   = S_IF;
      end
      S_MW: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
        if (bus.mem_rdy) state_nxt = S_IF;
      end
      S_BR: begin
        c.alu_srca = SRCA_REG;
        c.alu_srcb = SRCB_REG;
        c.alu_op   = ALU_SUB;
        c.pc_src   = PC_ALUOUT;
        c.pc_write = ((bus.op == OP_BEQ) && bus.zero) || ((bus.op == OP_BNE) && !bus.zero);
        state_nxt  = S_IF;
      end
      S_JMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = PC_JUMP;
        if (bus.op == OP_JAL) begin
          c.reg_write = 1'b1;
          c.reg_dst   = RD_R31;
          c.wd_sel    = WD_PC;
        end
        state_nxt = S_IF;
      end
      default: state_nxt = S_IF;
    endcase
    // Nothing may be issued while reset is held, even though state already reads IF.
    if (rst) begin
      c        = '0;
      c.alu_op = ALU_NOP;
    end
  end

  assign bus.ctl = c;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: expected control words are queued as each cycle's
// stimulus is driven and compared against the DUT at the falling edge.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  logic clk;
  logic rst;
  mc_ctrl_if bus ();

  mc_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  ctrl_t exp_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic ctrl_t e_idle();
    ctrl_t e;
    e = '0;
    e.alu_op = ALU_NOP;
    return e;
  endfunction

  function automatic ctrl_t e_if(logic rdy);
    ctrl_t e = e_idle();
    e.mem_read = 1'b1; e.alu_srca = SRCA_PC; e.alu_srcb = SRCB_FOUR; e.alu_op = ALU_ADDU;
    e.ir_write = rdy;  e.pc_write = rdy;     e.pc_src = PC_ALU;
    return e;
  endfunction

  function automatic ctrl_t e_id(logic ill);
    ctrl_t e = e_idle();
    e.alu_srca = SRCA_PC; e.alu_srcb = SRCB_IMM_SH; e.ext_op = 1'b1; e.alu_op = ALU_ADDU;
    e.illegal = ill;
    return e;
  endfunction

  function automatic ctrl_t e_exr(aluop_t a, logic sh);
    ctrl_t e = e_idle();
    e.alu_srca = sh ? SRCA_SHAMT : SRCA_REG; e.alu_srcb = SRCB_REG; e.alu_op = a;
    return e;
  endfunction

  function automatic ctrl_t e_exi(aluop_t a, logic sext);
    ctrl_t e = e_idle();
    e.alu_srca = SRCA_REG; e.alu_srcb = SRCB_IMM; e.ext_op = sext; e.alu_op = a;
    return e;
  endfunction

  function automatic ctrl_t e_wb(reg_dst_e d);
    ctrl_t e = e_idle();
    e.reg_write = 1'b1; e.wd_sel = WD_ALUOUT; e.reg_dst = d;
    return e;
  endfunction

  function automatic ctrl_t e_ma();
    ctrl_t e = e_idle();
    e.alu_srca = SRCA_REG; e.alu_srcb = SRCB_IMM; e.ext_op = 1'b1; e.alu_op = ALU_ADD;
    return e;
  endfunction

  function automatic ctrl_t e_mem(logic wr);
    ctrl_t e = e_idle();
    e.iord = 1'b1; e.mem_read = !wr; e.mem_write = wr;
    return e;
  endfunction

  function automatic ctrl_t e_wm();
    ctrl_t e = e_idle();
    e.reg_write = 1'b1; e.wd_sel = WD_MDR; e.reg_dst = RD_RT;
    return e;
  endfunction

  function automatic ctrl_t e_br(logic taken);
    ctrl_t e = e_idle();
    e.alu_srca = SRCA_REG; e.alu_srcb = SRCB_REG; e.alu_op = ALU_SUB;
    e.pc_src = PC_ALUOUT; e.pc_write = taken;
    return e;
  endfunction

  function automatic ctrl_t e_jmp(logic link);
    ctrl_t e = e_idle();
    e.pc_write = 1'b1; e.pc_src = PC_JUMP;
    if (link) begin
      e.reg_write = 1'b1; e.reg_dst = RD_R31; e.wd_sel = WD_PC;
    end
    return e;
  endfunction

  task automatic check_out();
    ctrl_t e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_cmp++;
    assert (bus.ctl === e) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", t, bus.ctl, e);
    end
  endtask

  // One clock cycle: drive inputs just after the rising edge, compare at the falling edge.
  task automatic step(input ctrl_t e, input string tag, input logic rdy, input logic z);
    bus.mem_rdy = rdy;
    bus.zero    = z;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_step(input string tag);
    bus.mem_rdy = 1'b0;
    rst = 1'b1;
    exp_q.push_back(e_idle());
    tag_q.push_back(tag);
    @(negedge clk);
    check_out();
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input op_t o, input op_t f);
    bus.op    = o;
    bus.funct = f;
  endtask

  initial begin
    rst = 1'b1;
    bus.op = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_rdy = 1'b0;
    reset_step("reset");

    // ADD with a one-cycle fetch stall up front
    set_instr(OP_RTYPE, F_ADD);
    step(e_if(1'b0), "add_if_stall", 1'b0, 1'b0);
    step(e_if(1'b1), "add_if", 1'b1, 1'b0);
    step(e_id(1'b0), "add_id", 1'b1, 1'b0);
    step(e_exr(ALU_ADD, 1'b0), "add_ex", 1'b1, 1'b0);
    step(e_wb(RD_RD), "add_wb", 1'b1, 1'b0);

    // ANDI: zero-extended immediate, writes rt
    set_instr(OP_ANDI, 6'h11);
    step(e_if(1'b1), "andi_if", 1'b1, 1'b0);
    step(e_id(1'b0), "andi_id", 1'b1, 1'b0);
    step(e_exi(ALU_AND, 1'b0), "andi_ex", 1'b1, 1'b0);
    step(e_wb(RD_RT), "andi_wb", 1'b1, 1'b0);

    // SLTI: sign-extended immediate
    set_instr(OP_SLTI, 6'h2A);
    step(e_if(1'b1), "slti_if", 1'b1, 1'b0);
    step(e_id(1'b0), "slti_id", 1'b1, 1'b0);
    step(e_exi(ALU_SLT, 1'b1), "slti_ex", 1'b1, 1'b0);
    step(e_wb(RD_RT), "slti_wb", 1'b1, 1'b0);

    // NOP word (SLL $0) uses the shamt source and writes rd
    set_instr(OP_RTYPE, F_SLL);
    step(e_if(1'b1), "nop_if", 1'b1, 1'b0);
    step(e_id(1'b0), "nop_id", 1'b1, 1'b0);
    step(e_exr(ALU_SLL, 1'b1), "nop_ex", 1'b1, 1'b0);
    step(e_wb(RD_RD), "nop_wb", 1'b1, 1'b0);

    // LW with two stall cycles in MR: 7 cycles total
    set_instr(OP_LW, 6'h04);
    step(e_if(1'b1), "lw_if", 1'b1, 1'b0);
    step(e_id(1'b0), "lw_id", 1'b1, 1'b0);
    step(e_ma(), "lw_ma", 1'b1, 1'b0);
    step(e_mem(1'b0), "lw_mr_stall0", 1'b0, 1'b0);
    step(e_mem(1'b0), "lw_mr_stall1", 1'b0, 1'b0);
    step(e_mem(1'b0), "lw_mr_rdy", 1'b1, 1'b0);
    step(e_wm(), "lw_wm", 1'b1, 1'b0);

    // SW with one stall cycle in MW
    set_instr(OP_SW, 6'h08);
    step(e_if(1'b1), "sw_if", 1'b1, 1'b0);
    step(e_id(1'b0), "sw_id", 1'b1, 1'b0);
    step(e_ma(), "sw_ma", 1'b1, 1'b0);
    step(e_mem(1'b1), "sw_mw_stall", 1'b0, 1'b0);
    step(e_mem(1'b1), "sw_mw_rdy", 1'b1, 1'b0);

    // Branches: taken when (BEQ & zero) or (BNE & !zero)
    set_instr(OP_BEQ, 6'h00);
    step(e_if(1'b1), "beq1_if", 1'b1, 1'b0);
    step(e_id(1'b0), "beq1_id", 1'b1, 1'b0);
    step(e_br(1'b1), "beq_z1", 1'b1, 1'b1);
    step(e_if(1'b1), "beq0_if", 1'b1, 1'b0);
    step(e_id(1'b0), "beq0_id", 1'b1, 1'b0);
    step(e_br(1'b0), "beq_z0", 1'b1, 1'b0);
    set_instr(OP_BNE, 6'h00);
    step(e_if(1'b1), "bne1_if", 1'b1, 1'b0);
    step(e_id(1'b0), "bne1_id", 1'b1, 1'b0);
    step(e_br(1'b0), "bne_z1", 1'b1, 1'b1);
    step(e_if(1'b1), "bne0_if", 1'b1, 1'b0);
    step(e_id(1'b0), "bne0_id", 1'b1, 1'b0);
    step(e_br(1'b1), "bne_z0", 1'b1, 1'b0);

    // Jumps
    set_instr(OP_J, 6'h15);
    step(e_if(1'b1), "j_if", 1'b1, 1'b0);
    step(e_id(1'b0), "j_id", 1'b1, 1'b0);
    step(e_jmp(1'b0), "j_jmp", 1'b1, 1'b0);
    set_instr(OP_JAL, 6'h15);
    step(e_if(1'b1), "jal_if", 1'b1, 1'b0);
    step(e_id(1'b0), "jal_id", 1'b1, 1'b0);
    step(e_jmp(1'b1), "jal_jmp", 1'b1, 1'b0);

    // Illegal opcode, then illegal R-type funct: back to fetch right after ID
    set_instr(6'h3F, 6'h00);
    step(e_if(1'b1), "ill_op_if", 1'b1, 1'b0);
    step(e_id(1'b1), "ill_op_id", 1'b1, 1'b0);
    set_instr(OP_RTYPE, 6'h01);
    step(e_if(1'b1), "ill_fn_if", 1'b1, 1'b0);
    step(e_id(1'b1), "ill_fn_id", 1'b1, 1'b0);

    // SUB after an I-type: rd flag must be set again
    set_instr(OP_RTYPE, F_SUB);
    step(e_if(1'b1), "sub_if", 1'b1, 1'b0);
    step(e_id(1'b0), "sub_id", 1'b1, 1'b0);
    step(e_exr(ALU_SUB, 1'b0), "sub_ex", 1'b1, 1'b0);
    step(e_wb(RD_RD), "sub_wb", 1'b1, 1'b0);

    // Reset asserted mid-MR drops the read and returns to IF
    set_instr(OP_LW, 6'h00);
    step(e_if(1'b1), "lwr_if", 1'b1, 1'b0);
    step(e_id(1'b0), "lwr_id", 1'b1, 1'b0);
    step(e_ma(), "lwr_ma", 1'b1, 1'b0);
    step(e_mem(1'b0), "lwr_mr_stall", 1'b0, 1'b0);
    reset_step("reset_mid_mr");
    set_instr(OP_RTYPE, F_OR);
    step(e_if(1'b1), "post_rst_if", 1'b1, 1'b0);
    step(e_id(1'b0), "post_rst_id", 1'b1, 1'b0);
    step(e_exr(ALU_OR, 1'b0), "post_rst_ex", 1'b1, 1'b0);
    step(e_wb(RD_RD), "post_rst_wb", 1'b1, 1'b0);
    step(e_if(1'b0), "final_if", 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
